// File: rtl/step_count_incr_pkg.sv
// Shared definitions for the step_count_incr up-counting step controller:
// FSM state encoding and the default counter width.
package step_count_incr_pkg;

    localparam int unsigned DefCntW = 3;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StDone = 2'b10
    } state_e;

endpackage

// File: rtl/step_count_incr_count_incr.sv
// count_incr: combinational W-bit +1 (modulo 2^W) producing the next step index.
module count_incr #(
    parameter int unsigned W = 3
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] sum
);

    // n-bit add with the second operand tied to constant 1; carry-out dropped
    assign sum = a + W'(1);

endmodule

// File: rtl/step_count_incr.sv
// Up-counting step controller for the radix-4 multiplier datapath.
// Optional `STEP_CNT_ABORT_EN adds an abort input that returns RUN to IDLE.
module step_count_incr
    import step_count_incr_pkg::*;
#(
    parameter int unsigned CNT_W = DefCntW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] last,
    input  logic             en,
`ifdef STEP_CNT_ABORT_EN
    input  logic             abort,
`endif
    output logic [CNT_W-1:0] step,
    output logic             busy,
    output logic             first,
    output logic             last_step,
    output logic             done
);

    state_e           state_q;
    logic [CNT_W-1:0] step_q;
    logic [CNT_W-1:0] last_q;
    logic [CNT_W-1:0] step_next;
    logic             busy_q;
    logic             done_q;

    count_incr #(
        .W(CNT_W)
    ) u_count_incr (
        .a  (step_q),
        .sum(step_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= '0;
            last_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                // DONE accepts a new start directly so sequences can run back to back
                StIdle, StDone: begin
                    if (start) begin
                        state_q <= StRun;
                        step_q  <= '0;
                        last_q  <= last;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
`ifdef STEP_CNT_ABORT_EN
                    if (abort) begin
                        state_q <= StIdle;
                        step_q  <= '0;
                        busy_q  <= 1'b0;
                    end else
`endif
                    if (en) begin
                        if (step_q == last_q) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            step_q <= step_next;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign step      = step_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign first     = busy_q && (step_q == '0);
    assign last_step = busy_q && (step_q == last_q);

endmodule

// File: tb/tb_step_count_incr.sv
// Self-checking bench for step_count_incr: per-cycle expected outputs are queued
// as stimulus is driven and compared after each clock edge.
module tb_step_count_incr;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] last = 3'd0;
    logic       en = 1'b0;
`ifdef STEP_CNT_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic [2:0] step;
    logic       busy;
    logic       first;
    logic       last_step;
    logic       done;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [6:0]  sb [$];

    always #5 clk = ~clk;

    step_count_incr #(
        .CNT_W(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .last     (last),
        .en       (en),
`ifdef STEP_CNT_ABORT_EN
        .abort    (abort),
`endif
        .step     (step),
        .busy     (busy),
        .first    (first),
        .last_step(last_step),
        .done     (done)
    );

    // Packed observation: {busy, first, last_step, done, step}
    function automatic logic [6:0] mk(int b, int f, int l, int d, int s);
        logic [31:0] sv;
        sv = s;
        return {b != 0, f != 0, l != 0, d != 0, sv[2:0]};
    endfunction

    function automatic logic [6:0] obs();
        return {busy, first, last_step, done, step};
    endfunction

    task automatic drive(input logic s, input logic [2:0] l, input logic e);
        start = s;
        last  = l;
        en    = e;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] got;
        #3;
        got = obs();
        n_cmp++;
        if (got !== 7'd0) begin
            n_err++;
            $display("FAIL reset_async: got %b want %b", got, 7'd0);
        end
        @(posedge clk);
        #1;
        got = obs();
        n_cmp++;
        if (got !== 7'd0) begin
            n_err++;
            $display("FAIL reset_held: got %b want %b", got, 7'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic       st [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       ev [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [6:0] ex [6];
        logic [6:0] got, want;
        ex = '{mk(1,1,0,0,0), mk(1,0,0,0,1), mk(1,0,0,0,2), mk(1,0,1,0,3),
               mk(0,0,0,1,3), mk(0,0,0,0,3)};
        for (int i = 0; i < 6; i++) begin
            sb.push_back(ex[i]);
            drive(st[i], 3'd3, ev[i]);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL basic[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_en_toggle();
        logic       st [9] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       ev [9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0] lv [9] = '{3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
        logic [6:0] ex [9];
        logic [6:0] got, want;
        ex = '{mk(1,1,0,0,0), mk(1,0,0,0,1), mk(1,0,0,0,1), mk(1,0,0,0,2),
               mk(1,0,0,0,2), mk(1,0,1,0,3), mk(1,0,1,0,3), mk(0,0,0,1,3),
               mk(0,0,0,0,3)};
        for (int i = 0; i < 9; i++) begin
            sb.push_back(ex[i]);
            drive(st[i], lv[i], ev[i]);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL en_toggle[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_single_step();
        logic       st [3] = '{1'b1, 1'b0, 1'b0};
        logic       ev [3] = '{1'b1, 1'b1, 1'b1};
        logic [6:0] ex [3];
        logic [6:0] got, want;
        ex = '{mk(1,1,1,0,0), mk(0,0,0,1,0), mk(0,0,0,0,0)};
        for (int i = 0; i < 3; i++) begin
            sb.push_back(ex[i]);
            drive(st[i], 3'd0, ev[i]);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL single_step[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_full_range();
        logic [6:0] got, want;
        for (int i = 0; i < 11; i++) begin
            if (i <= 7)      sb.push_back(mk(1, i == 0, i == 7, 0, i));
            else if (i == 8) sb.push_back(mk(0, 0, 0, 1, 7));
            else             sb.push_back(mk(0, 0, 0, 0, 7));
            drive(i == 0, 3'd7, i <= 8);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL full_range[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       st [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ev [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [6:0] ex [7];
        logic [6:0] got, want;
        ex = '{mk(1,1,0,0,0), mk(1,0,1,0,1), mk(0,0,0,1,1), mk(1,1,0,0,0),
               mk(1,0,1,0,1), mk(0,0,0,1,1), mk(0,0,0,0,1)};
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ex[i]);
            drive(st[i], 3'd1, ev[i]);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %b want %b", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] got, want;
        for (int i = 0; i < 3; i++) begin
            sb.push_back(mk(1, i == 0, 0, 0, i));
            drive(i == 0, 3'd5, 1'b1);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL reset_mid_run[%0d]: got %b want %b", i, got, want);
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        got = obs();
        n_cmp++;
        if (got !== 7'd0) begin
            n_err++;
            $display("FAIL reset_mid_async: got %b want %b", got, 7'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            got = obs();
            n_cmp++;
            if (got !== 7'd0) begin
                n_err++;
                $display("FAIL reset_mid_after[%0d]: got %b want %b", i, got, 7'd0);
            end
        end
    endtask

`ifdef STEP_CNT_ABORT_EN
    task automatic test_abort();
        logic       st [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        logic       ab [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [6:0] ex [5];
        logic [6:0] got, want;
        ex = '{mk(1,1,0,0,0), mk(1,0,0,0,1), mk(0,0,0,0,0), mk(0,0,0,0,0),
               mk(1,1,0,0,0)};
        for (int i = 0; i < 5; i++) begin
            sb.push_back(ex[i]);
            abort = ab[i];
            drive(st[i], 3'd5, 1'b1);
            got  = obs();
            want = sb.pop_front();
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL abort[%0d]: got %b want %b", i, got, want);
            end
        end
        abort = 1'b0;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_en_toggle();
        test_single_step();
        test_full_range();
        test_back_to_back();
        test_reset_mid();
`ifdef STEP_CNT_ABORT_EN
        test_abort();
`endif
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
